openofdm_rx_seq_ctrl: RTL and testbench

//  Receive-sequence supervisor beside dot11 in openofdm_rx.

---
 rtl/openofdm_rx_seq_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_openofdm_rx_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/openofdm_rx_seq_ctrl.sv
// Receive-sequence supervisor for openofdm_rx: tracks each packet phase and requests a dot11 reset on stall/bad header.
// Optional statistics counters are enabled by defining OPENOFDM_RX_SEQ_STAT_CNT_EN.
module openofdm_rx_seq_ctrl #(
    parameter int TMO_WIDTH     = 16,
    parameter int RST_PULSE_LEN = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 s00_axi_aclk,
    input  logic                 s00_axi_aresetn,
    input  logic                 enable,
    input  logic                 sample_in_strobe,
    input  logic                 short_preamble_detected,
    input  logic                 long_preamble_detected,
    input  logic                 pkt_header_valid_strobe,
    input  logic                 pkt_header_valid,
    input  logic                 ht_unsupport,
    input  logic [14:0]          n_ofdm_sym,
    input  logic                 phy_len_valid,
    input  logic                 ofdm_symbol_eq_out_pulse,
    input  logic                 fcs_out_strobe,
    input  logic                 fcs_ok,
`ifdef OPENOFDM_RX_SEQ_STAT_CNT_EN
    input  logic                 stat_clr,
    output logic [CNT_WIDTH-1:0] pkt_ok_cnt,
    output logic [CNT_WIDTH-1:0] pkt_fcs_err_cnt,
    output logic [CNT_WIDTH-1:0] abort_cnt,
`endif
    input  logic [TMO_WIDTH-1:0] long_tmo_th,
    input  logic [TMO_WIDTH-1:0] hdr_tmo_th,
    input  logic [TMO_WIDTH-1:0] sym_tmo_th,
    output logic                 receiver_rst,
    output logic [2:0]           seq_state,
    output logic [2:0]           abort_code,
    output logic                 pkt_done_strobe,
    output logic                 pkt_fcs_ok
);

    localparam int RCW = (RST_PULSE_LEN < 1) ? 1 : $clog2(RST_PULSE_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LONG = 3'd1,
        S_WAIT_HDR  = 3'd2,
        S_WAIT_LEN  = 3'd3,
        S_DATA      = 3'd4,
        S_WAIT_FCS  = 3'd5,
        S_RESET     = 3'd6
    } state_t;

    state_t               state, next_state;
    logic [TMO_WIDTH-1:0] timer;
    logic [14:0]          sym_cnt;
    logic [14:0]          n_lat;
    logic [RCW-1:0]       rst_cnt;
    logic                 rst_q;

    logic [TMO_WIDTH-1:0] tmo_th;
    logic [2:0]           tmo_code;
    logic                 tmo_hit;
    logic                 abort_go;
    logic [2:0]           abort_nxt;
    logic                 done_go;
    logic                 len_go;
    logic                 sym_go;

    always_comb begin
        tmo_th   = '0;
        tmo_code = 3'd0;
        case (state)
            S_WAIT_LONG: begin
                tmo_th   = long_tmo_th;
                tmo_code = 3'd1;
            end
            S_WAIT_HDR, S_WAIT_LEN: begin
                tmo_th   = hdr_tmo_th;
                tmo_code = 3'd2;
            end
            S_DATA, S_WAIT_FCS: begin
                tmo_th   = sym_tmo_th;
                tmo_code = 3'd5;
            end
            default: ;
        endcase
        tmo_hit = (tmo_th != '0) && (timer == tmo_th);
    end

    // Each state checks its progress event first so a same-cycle timeout never aborts.
    always_comb begin
        next_state = state;
        abort_go   = 1'b0;
        abort_nxt  = abort_code;
        done_go    = 1'b0;
        len_go     = 1'b0;
        sym_go     = 1'b0;
        case (state)
            S_IDLE: begin
                if (short_preamble_detected) next_state = S_WAIT_LONG;
            end
            S_WAIT_LONG: begin
                if (long_preamble_detected) next_state = S_WAIT_HDR;
                else if (tmo_hit) begin
                    abort_go  = 1'b1;
                    abort_nxt = tmo_code;
                end
            end
            S_WAIT_HDR: begin
                if (pkt_header_valid_strobe) begin
                    if (!pkt_header_valid) begin
                        abort_go  = 1'b1;
                        abort_nxt = 3'd3;
                    end else if (ht_unsupport) begin
                        abort_go  = 1'b1;
                        abort_nxt = 3'd4;
                    end else begin
                        next_state = S_WAIT_LEN;
                    end
                end else if (tmo_hit) begin
                    abort_go  = 1'b1;
                    abort_nxt = tmo_code;
                end
            end
            S_WAIT_LEN: begin
                if (phy_len_valid) begin
                    len_go     = 1'b1;
                    next_state = (n_ofdm_sym == 15'd0) ? S_WAIT_FCS : S_DATA;
                end else if (tmo_hit) begin
                    abort_go  = 1'b1;
                    abort_nxt = tmo_code;
                end
            end
            S_DATA: begin
                if (fcs_out_strobe) begin
                    done_go    = 1'b1;
                    next_state = S_IDLE;
                end else if (ofdm_symbol_eq_out_pulse) begin
                    sym_go = 1'b1;
                    if (sym_cnt + 15'd1 == n_lat) next_state = S_WAIT_FCS;
                end else if (tmo_hit) begin
                    abort_go  = 1'b1;
                    abort_nxt = tmo_code;
                end
            end
            S_WAIT_FCS: begin
                if (fcs_out_strobe) begin
                    done_go    = 1'b1;
                    next_state = S_IDLE;
                end else if (!ofdm_symbol_eq_out_pulse && tmo_hit) begin
                    abort_go  = 1'b1;
                    abort_nxt = tmo_code;
                end
            end
            S_RESET: begin
                if (rst_cnt == RCW'(RST_PULSE_LEN)) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        if (abort_go) next_state = S_RESET;
        if (!enable) begin
            next_state = S_IDLE;
            abort_go   = 1'b0;
            abort_nxt  = abort_code;
            done_go    = 1'b0;
            len_go     = 1'b0;
            sym_go     = 1'b0;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state           <= S_IDLE;
            timer           <= '0;
            sym_cnt         <= '0;
            n_lat           <= '0;
            rst_cnt         <= '0;
            rst_q           <= 1'b0;
            abort_code      <= 3'd0;
            pkt_done_strobe <= 1'b0;
            pkt_fcs_ok      <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state || ofdm_symbol_eq_out_pulse) timer <= '0;
            else if (sample_in_strobe && timer != '1) timer <= timer + 1'b1;
            if (len_go) begin
                n_lat   <= n_ofdm_sym;
                sym_cnt <= '0;
            end else if (sym_go) begin
                sym_cnt <= sym_cnt + 15'd1;
            end
            // The pulse starts on the first RESET cycle's edge and ends on the edge that returns to IDLE.
            if (state == S_RESET && next_state == S_RESET) begin
                rst_cnt <= rst_cnt + 1'b1;
                rst_q   <= 1'b1;
            end else begin
                rst_cnt <= '0;
                rst_q   <= 1'b0;
            end
            abort_code      <= abort_nxt;
            pkt_done_strobe <= done_go;
            if (done_go) pkt_fcs_ok <= fcs_ok;
        end
    end

`ifdef OPENOFDM_RX_SEQ_STAT_CNT_EN
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn || stat_clr) begin
            pkt_ok_cnt      <= '0;
            pkt_fcs_err_cnt <= '0;
            abort_cnt       <= '0;
        end else begin
            if (done_go && fcs_ok && pkt_ok_cnt != '1) pkt_ok_cnt <= pkt_ok_cnt + 1'b1;
            if (done_go && !fcs_ok && pkt_fcs_err_cnt != '1) pkt_fcs_err_cnt <= pkt_fcs_err_cnt + 1'b1;
            if (abort_go && abort_cnt != '1) abort_cnt <= abort_cnt + 1'b1;
        end
    end
`endif

    // Gated so that dropping enable releases dot11 without waiting for a clock edge.
    assign receiver_rst = rst_q & enable & s00_axi_aresetn;
    assign seq_state    = state;

endmodule

// File: tb/tb_openofdm_rx_seq_ctrl.sv
// Directed self-checking bench for openofdm_rx_seq_ctrl.
// Define OPENOFDM_RX_SEQ_STAT_CNT_EN to also exercise the statistics counters.
module tb_openofdm_rx_seq_ctrl;

    localparam logic [6:0] P_SP  = 7'h01;
    localparam logic [6:0] P_LP  = 7'h02;
    localparam logic [6:0] P_HDR = 7'h04;
    localparam logic [6:0] P_LEN = 7'h08;
    localparam logic [6:0] P_SYM = 7'h10;
    localparam logic [6:0] P_FCS = 7'h20;
    localparam logic [6:0] P_SMP = 7'h40;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        sample_in_strobe;
    logic        short_preamble_detected;
    logic        long_preamble_detected;
    logic        pkt_header_valid_strobe;
    logic        pkt_header_valid;
    logic        ht_unsupport;
    logic [14:0] n_ofdm_sym;
    logic        phy_len_valid;
    logic        ofdm_symbol_eq_out_pulse;
    logic        fcs_out_strobe;
    logic        fcs_ok;
    logic [15:0] long_tmo_th;
    logic [15:0] hdr_tmo_th;
    logic [15:0] sym_tmo_th;
    logic        receiver_rst;
    logic [2:0]  seq_state;
    logic [2:0]  abort_code;
    logic        pkt_done_strobe;
    logic        pkt_fcs_ok;
`ifdef OPENOFDM_RX_SEQ_STAT_CNT_EN
    logic        stat_clr;
    logic [15:0] pkt_ok_cnt;
    logic [15:0] pkt_fcs_err_cnt;
    logic [15:0] abort_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int rst_hi_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (receiver_rst === 1'b1) rst_hi_cnt++;

    openofdm_rx_seq_ctrl dut (
        .s00_axi_aclk             (clk),
        .s00_axi_aresetn          (aresetn),
        .enable                   (enable),
        .sample_in_strobe         (sample_in_strobe),
        .short_preamble_detected  (short_preamble_detected),
        .long_preamble_detected   (long_preamble_detected),
        .pkt_header_valid_strobe  (pkt_header_valid_strobe),
        .pkt_header_valid         (pkt_header_valid),
        .ht_unsupport             (ht_unsupport),
        .n_ofdm_sym               (n_ofdm_sym),
        .phy_len_valid            (phy_len_valid),
        .ofdm_symbol_eq_out_pulse (ofdm_symbol_eq_out_pulse),
        .fcs_out_strobe           (fcs_out_strobe),
        .fcs_ok                   (fcs_ok),
`ifdef OPENOFDM_RX_SEQ_STAT_CNT_EN
        .stat_clr                 (stat_clr),
        .pkt_ok_cnt               (pkt_ok_cnt),
        .pkt_fcs_err_cnt          (pkt_fcs_err_cnt),
        .abort_cnt                (abort_cnt),
`endif
        .long_tmo_th              (long_tmo_th),
        .hdr_tmo_th               (hdr_tmo_th),
        .sym_tmo_th               (sym_tmo_th),
        .receiver_rst             (receiver_rst),
        .seq_state                (seq_state),
        .abort_code               (abort_code),
        .pkt_done_strobe          (pkt_done_strobe),
        .pkt_fcs_ok               (pkt_fcs_ok)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Raise the selected one-cycle pulses across exactly one rising edge.
    task automatic applyStimulus(input logic [6:0] p);
        short_preamble_detected  = p[0];
        long_preamble_detected   = p[1];
        pkt_header_valid_strobe  = p[2];
        phy_len_valid            = p[3];
        ofdm_symbol_eq_out_pulse = p[4];
        fcs_out_strobe           = p[5];
        sample_in_strobe         = p[6];
        @(posedge clk);
        #1;
        short_preamble_detected  = 1'b0;
        long_preamble_detected   = 1'b0;
        pkt_header_valid_strobe  = 1'b0;
        phy_len_valid            = 1'b0;
        ofdm_symbol_eq_out_pulse = 1'b0;
        fcs_out_strobe           = 1'b0;
        sample_in_strobe         = 1'b0;
    endtask

    task automatic repeatStimulus(input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) applyStimulus(p);
    endtask

    task automatic goToData(input logic [14:0] n);
        applyStimulus(P_SP);
        applyStimulus(P_LP);
        pkt_header_valid = 1'b1;
        ht_unsupport     = 1'b0;
        applyStimulus(P_HDR);
        n_ofdm_sym = n;
        applyStimulus(P_LEN);
    endtask

    initial begin
        aresetn = 1'b0; enable = 1'b1;
        sample_in_strobe = 0; short_preamble_detected = 0; long_preamble_detected = 0;
        pkt_header_valid_strobe = 0; pkt_header_valid = 0; ht_unsupport = 0; n_ofdm_sym = '0;
        phy_len_valid = 0; ofdm_symbol_eq_out_pulse = 0; fcs_out_strobe = 0; fcs_ok = 0;
        long_tmo_th = '0; hdr_tmo_th = '0; sym_tmo_th = '0;
`ifdef OPENOFDM_RX_SEQ_STAT_CNT_EN
        stat_clr = 1'b0;
`endif
        repeatStimulus(0, 3);
        checkOutput("rst_state", 32'(seq_state), 0);
        checkOutput("rst_receiver_rst", 32'(receiver_rst), 0);
        checkOutput("rst_abort_code", 32'(abort_code), 0);
        checkOutput("rst_done", 32'(pkt_done_strobe), 0);
        checkOutput("rst_fcs_ok", 32'(pkt_fcs_ok), 0);
        aresetn = 1'b1;
        applyStimulus(0);
        checkOutput("idle_after_reset", 32'(seq_state), 0);

        $display("[TB] good packet, n=3");
        rst_hi_cnt = 0;
        applyStimulus(P_SP);   checkOutput("good_wait_long", 32'(seq_state), 1);
        applyStimulus(P_LP);   checkOutput("good_wait_hdr", 32'(seq_state), 2);
        pkt_header_valid = 1'b1;
        applyStimulus(P_HDR);  checkOutput("good_wait_len", 32'(seq_state), 3);
        n_ofdm_sym = 15'd3;
        applyStimulus(P_LEN);  checkOutput("good_data", 32'(seq_state), 4);
        applyStimulus(P_SYM);  checkOutput("good_sym1", 32'(seq_state), 4);
        applyStimulus(P_SYM);  checkOutput("good_sym2", 32'(seq_state), 4);
        applyStimulus(P_SYM);  checkOutput("good_wait_fcs", 32'(seq_state), 5);
        applyStimulus(P_SYM);  checkOutput("extra_sym_ignored", 32'(seq_state), 5);
        fcs_ok = 1'b1;
        applyStimulus(P_FCS);
        checkOutput("good_idle", 32'(seq_state), 0);
        checkOutput("good_done", 32'(pkt_done_strobe), 1);
        checkOutput("good_fcs_ok", 32'(pkt_fcs_ok), 1);
        applyStimulus(0);
        checkOutput("good_done_one_cycle", 32'(pkt_done_strobe), 0);
        checkOutput("good_no_rst", 32'(rst_hi_cnt), 0);

        $display("[TB] long preamble timeout");
        long_tmo_th = 16'd100;
        applyStimulus(P_SP);
        repeatStimulus(P_SMP, 99);
        checkOutput("long_tmo_99", 32'(seq_state), 1);
        applyStimulus(P_SMP);
        checkOutput("long_tmo_100", 32'(seq_state), 1);
        rst_hi_cnt = 0;
        applyStimulus(0);
        checkOutput("long_tmo_reset", 32'(seq_state), 6);
        checkOutput("long_tmo_code", 32'(abort_code), 1);
        checkOutput("rst_not_yet", 32'(receiver_rst), 0);
        applyStimulus(0);
        checkOutput("rst_high", 32'(receiver_rst), 1);
        applyStimulus(P_SP);
        checkOutput("sp_ignored_in_reset", 32'(seq_state), 6);
        repeatStimulus(0, 2);
        checkOutput("rst_high_last", 32'(receiver_rst), 1);
        applyStimulus(0);
        checkOutput("reset_to_idle", 32'(seq_state), 0);
        checkOutput("rst_low_again", 32'(receiver_rst), 0);
        checkOutput("rst_pulse_len", 32'(rst_hi_cnt), 4);
        checkOutput("abort_sticky", 32'(abort_code), 1);
        long_tmo_th = '0;

        $display("[TB] header aborts");
        applyStimulus(P_SP);
        applyStimulus(P_LP);
        pkt_header_valid = 1'b0;
        applyStimulus(P_HDR);
        checkOutput("hdr_bad_state", 32'(seq_state), 6);
        checkOutput("hdr_bad_code", 32'(abort_code), 3);
        repeatStimulus(0, 5);
        checkOutput("hdr_bad_idle", 32'(seq_state), 0);
        applyStimulus(P_SP);
        applyStimulus(P_LP);
        pkt_header_valid = 1'b1;
        ht_unsupport = 1'b1;
        applyStimulus(P_HDR);
        checkOutput("ht_unsup_state", 32'(seq_state), 6);
        checkOutput("ht_unsup_code", 32'(abort_code), 4);
        ht_unsupport = 1'b0;
        repeatStimulus(0, 5);
        checkOutput("ht_unsup_idle", 32'(seq_state), 0);

        $display("[TB] header timeout");
        hdr_tmo_th = 16'd3;
        applyStimulus(P_SP);
        applyStimulus(P_LP);
        repeatStimulus(P_SMP, 3);
        checkOutput("hdr_tmo_pending", 32'(seq_state), 2);
        applyStimulus(0);
        checkOutput("hdr_tmo_code", 32'(abort_code), 2);
        repeatStimulus(0, 5);
        hdr_tmo_th = '0;

        $display("[TB] symbol timeout");
        sym_tmo_th = 16'd200;
        goToData(15'd5);
        repeatStimulus(P_SYM, 2);
        repeatStimulus(P_SMP, 200);
        checkOutput("sym_tmo_pending", 32'(seq_state), 4);
        applyStimulus(0);
        checkOutput("sym_tmo_state", 32'(seq_state), 6);
        checkOutput("sym_tmo_code", 32'(abort_code), 5);
        repeatStimulus(0, 5);
        goToData(15'd5);
        repeatStimulus(P_SMP, 200);
        applyStimulus(P_SYM);
        checkOutput("sym_beats_tmo", 32'(seq_state), 4);
        applyStimulus(0);
        checkOutput("sym_timer_cleared", 32'(seq_state), 4);
        repeatStimulus(P_SYM, 4);
        checkOutput("tmo_pkt_wait_fcs", 32'(seq_state), 5);
        fcs_ok = 1'b0;
        applyStimulus(P_FCS);
        checkOutput("fcs_bad_done", 32'(pkt_done_strobe), 1);
        checkOutput("fcs_bad_flag", 32'(pkt_fcs_ok), 0);
        sym_tmo_th = '0;

        $display("[TB] enable drop and no-timeout stall");
        goToData(15'd5);
        checkOutput("en_in_data", 32'(seq_state), 4);
        enable = 1'b0;
        applyStimulus(0);
        checkOutput("en_off_idle", 32'(seq_state), 0);
        checkOutput("en_off_no_rst", 32'(receiver_rst), 0);
        enable = 1'b1;
        applyStimulus(P_SP);
        applyStimulus(P_LP);
        pkt_header_valid = 1'b0;
        applyStimulus(P_HDR);
        applyStimulus(0);
        checkOutput("rst_before_drop", 32'(receiver_rst), 1);
        enable = 1'b0;
        #1;
        checkOutput("rst_drops_now", 32'(receiver_rst), 0);
        applyStimulus(0);
        checkOutput("drop_to_idle", 32'(seq_state), 0);
        checkOutput("drop_keeps_code", 32'(abort_code), 3);
        enable = 1'b1;
        pkt_header_valid = 1'b1;
        applyStimulus(P_SP);
        applyStimulus(P_LP);
        repeatStimulus(P_SMP, 300);
        checkOutput("stall_no_abort", 32'(seq_state), 2);
        applyStimulus(P_SP);
        checkOutput("sp_no_restart", 32'(seq_state), 2);
        enable = 1'b0;
        applyStimulus(0);
        enable = 1'b1;
        checkOutput("stall_exit", 32'(seq_state), 0);

`ifdef OPENOFDM_RX_SEQ_STAT_CNT_EN
        $display("[TB] statistics counters");
        stat_clr = 1'b1;
        applyStimulus(0);
        stat_clr = 1'b0;
        checkOutput("stat_clr_ok", 32'(pkt_ok_cnt), 0);
        for (int k = 0; k < 3; k++) begin
            goToData(15'd1);
            applyStimulus(P_SYM);
            fcs_ok = (k != 2);
            applyStimulus(P_FCS);
        end
        applyStimulus(P_SP);
        applyStimulus(P_LP);
        pkt_header_valid = 1'b0;
        applyStimulus(P_HDR);
        pkt_header_valid = 1'b1;
        repeatStimulus(0, 5);
        checkOutput("stat_ok", 32'(pkt_ok_cnt), 2);
        checkOutput("stat_fcs_err", 32'(pkt_fcs_err_cnt), 1);
        checkOutput("stat_abort", 32'(abort_cnt), 1);
        stat_clr = 1'b1;
        applyStimulus(0);
        stat_clr = 1'b0;
        checkOutput("stat_clr_ok2", 32'(pkt_ok_cnt), 0);
        checkOutput("stat_clr_err", 32'(pkt_fcs_err_cnt), 0);
        checkOutput("stat_clr_abort", 32'(abort_cnt), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
